button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 153 +++++++++++++++
 tb/tb_button_conditioner.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// ============================================================================
// button_conditioner
//   Debounces raw pushbuttons into clean levels and one-cycle press pulses,
//   with optional hold-to-auto-repeat per channel. Timing advances on CE only.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module button_conditioner #(
  parameter int             N               = 3,
  parameter int             DEBOUNCE_CYCLES = 20000,
  parameter int             REPEAT_DELAY    = 500000,
  parameter int             REPEAT_PERIOD   = 100000,
  parameter logic [N-1:0]   REPEAT_MASK     = 3'b100
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         CE,
  input  logic [N-1:0] BTN_RAW,
  output logic [N-1:0] BTN_LEVEL,
  output logic [N-1:0] BTN_PULSE
);

  localparam int c_DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_RCW  = $clog2(c_RMAX + 1);

  // Terminal values: a count sitting at these reaches the target on this CE cycle.
  localparam logic [c_DBW-1:0] c_DB_LAST = c_DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_RCW-1:0] c_RD_LAST = c_RCW'(REPEAT_DELAY - 1);
  localparam logic [c_RCW-1:0] c_RP_LAST = c_RCW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  logic [N-1:0] r_s1;
  logic [N-1:0] r_s2;

  // Synchronizer runs every cycle so CE gating never stretches metastability windows.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= BTN_RAW;
      r_s2 <= r_s1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [c_DBW-1:0] r_cnt;
    logic             r_lvl;
    logic             r_pls;
    logic [c_RCW-1:0] r_rcnt;
    logic [c_RCW-1:0] w_rcnt_nxt;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_pls_nxt;
    logic             w_accept;
    logic             w_rise;
    logic             w_fall;

    assign w_accept = CE && (r_s2[i] != r_lvl) && (r_cnt == c_DB_LAST);
    assign w_rise   = w_accept && !r_lvl;
    assign w_fall   = w_accept &&  r_lvl;

    always_ff @(posedge CLK) begin
      if (CLR) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (CE) begin
        if (r_s2[i] != r_lvl) begin
          if (r_cnt == c_DB_LAST) begin
            r_lvl <= r_s2[i];
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (CLR) begin
        r_state <= S_IDLE;
        r_rcnt  <= '0;
        r_pls   <= 1'b0;
      end else if (CE) begin
        r_state <= w_state_nxt;
        r_rcnt  <= w_rcnt_nxt;
        r_pls   <= w_pls_nxt;
      end else begin
        r_pls   <= 1'b0;
      end
    end

    // Release is checked first so it wins over a repeat falling due the same cycle.
    always_comb begin
      w_state_nxt = r_state;
      w_rcnt_nxt  = r_rcnt;
      w_pls_nxt   = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            w_pls_nxt   = 1'b1;
            w_rcnt_nxt  = '0;
            w_state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_fall) begin
            w_rcnt_nxt  = '0;
            w_state_nxt = S_IDLE;
          end else if (REPEAT_MASK[i]) begin
            if (r_rcnt == c_RD_LAST) begin
              w_pls_nxt   = 1'b1;
              w_rcnt_nxt  = '0;
              w_state_nxt = S_REPEAT;
            end else begin
              w_rcnt_nxt  = r_rcnt + 1'b1;
            end
          end
        end
        S_REPEAT: begin
          if (w_fall) begin
            w_rcnt_nxt  = '0;
            w_state_nxt = S_IDLE;
          end else if (r_rcnt == c_RP_LAST) begin
            w_pls_nxt   = 1'b1;
            w_rcnt_nxt  = '0;
          end else begin
            w_rcnt_nxt  = r_rcnt + 1'b1;
          end
        end
        default: begin
          w_rcnt_nxt  = '0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    assign BTN_LEVEL[i] = r_lvl;
    assign BTN_PULSE[i] = r_pls;
  end

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// tb_button_conditioner
//   Directed and randomized checks of button_conditioner against a
//   history-based reference model.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_button_conditioner;

  localparam int         N    = 3;
  localparam int         D    = 4;
  localparam int         RD   = 8;
  localparam int         RP   = 3;
  localparam logic [2:0] MASK = 3'b100;

  logic         CLK = 1'b0;
  logic         CLR;
  logic         CE;
  logic [N-1:0] BTN_RAW;
  logic [N-1:0] BTN_LEVEL;
  logic [N-1:0] BTN_PULSE;

  int checks = 0;
  int errors = 0;

  // Reference model: synchronizer pipe, per-channel history of CE-cycle
  // mismatch flags, and a count of CE cycles since the press was accepted.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_pls;
  bit           m_hist [N][$];
  bit           m_held [N];
  int           m_k    [N];

  button_conditioner #(
    .N               (N),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .REPEAT_MASK     (MASK)
  ) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .CE        (CE),
    .BTN_RAW   (BTN_RAW),
    .BTN_LEVEL (BTN_LEVEL),
    .BTN_PULSE (BTN_PULSE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] s2_old;
    bit           all_mis;
    bit           rose, fell;
    if (CLR) begin
      m_s1  = '0;
      m_s2  = '0;
      m_lvl = '0;
      m_pls = '0;
      for (int ch = 0; ch < N; ch++) begin
        m_held[ch] = 1'b0;
        m_k[ch]    = 0;
        m_hist[ch].delete();
      end
    end else begin
      s2_old = m_s2;
      m_s2   = m_s1;
      m_s1   = BTN_RAW;
      m_pls  = '0;
      if (CE) begin
        for (int ch = 0; ch < N; ch++) begin
          rose = 1'b0;
          fell = 1'b0;
          m_hist[ch].push_back(s2_old[ch] != m_lvl[ch]);
          if (m_hist[ch].size() > D) void'(m_hist[ch].pop_front());
          all_mis = (m_hist[ch].size() == D);
          for (int j = 0; j < m_hist[ch].size(); j++)
            if (!m_hist[ch][j]) all_mis = 1'b0;
          if (all_mis) begin
            if (m_lvl[ch]) fell = 1'b1;
            else           rose = 1'b1;
            m_lvl[ch] = ~m_lvl[ch];
            m_hist[ch].delete();
          end
          if (rose) begin
            m_pls[ch]  = 1'b1;
            m_held[ch] = 1'b1;
            m_k[ch]    = 0;
          end else if (fell) begin
            m_held[ch] = 1'b0;
          end else if (m_held[ch] && MASK[ch]) begin
            m_k[ch]++;
            if (m_k[ch] == RD || (m_k[ch] > RD && (m_k[ch] - RD) % RP == 0))
              m_pls[ch] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk("level", BTN_LEVEL, m_lvl);
    chk("pulse", BTN_PULSE, m_pls);
    if (!CE) chk("ce0_pulse", BTN_PULSE, '0);
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  initial begin
    CLR     = 1'b1;
    CE      = 1'b1;
    BTN_RAW = '0;

    // Reset state
    hold(2);
    chk("rst_level", BTN_LEVEL, 3'b000);
    chk("rst_pulse", BTN_PULSE, 3'b000);
    CLR = 1'b0;
    hold(3);

    // Clean press on SELECT: single pulse at t=6, no repeat
    BTN_RAW = 3'b001;
    for (int t = 1; t <= 30; t++) begin
      step();
      if (t == 5) chk("press_level_t5", BTN_LEVEL, 3'b000);
      if (t == 6) chk("press_pulse_t6", BTN_PULSE, 3'b001);
      if (t == 6) chk("press_level_t6", BTN_LEVEL, 3'b001);
      if (t > 6)  chk("press_no_repeat", BTN_PULSE, 3'b000);
    end
    BTN_RAW = 3'b000;
    hold(10);

    // Bounce rejection on STOP
    for (int j = 0; j < 40; j++) begin
      BTN_RAW[1] = (j % 4 != 3);
      step();
      chk("bounce_level", BTN_LEVEL, 3'b000);
      chk("bounce_pulse", BTN_PULSE, 3'b000);
    end
    BTN_RAW[1] = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      step();
      if (t == 6) chk("bounce_settle_pulse", BTN_PULSE, 3'b010);
    end
    BTN_RAW = 3'b000;
    hold(10);

    // Auto-repeat on SET
    BTN_RAW = 3'b100;
    for (int t = 1; t <= 30; t++) begin
      step();
      chk("repeat_pulse", BTN_PULSE,
          (t == 6 || t == 14 || t == 17 || t == 20 || t == 23 || t == 26 || t == 29)
          ? 3'b100 : 3'b000);
    end
    BTN_RAW = 3'b000;
    for (int t = 1; t <= 6; t++) begin
      step();
      if (t == 5) chk("release_level_t5", BTN_LEVEL, 3'b100);
      if (t == 6) chk("release_level_t6", BTN_LEVEL, 3'b000);
      if (t == 6) chk("release_no_pulse", BTN_PULSE, 3'b000);
    end
    hold(6);

    // CE gating: CE alternates, SELECT pressed then released
    BTN_RAW = 3'b001;
    for (int t = 1; t <= 30; t++) begin
      CE = t[0];
      step();
    end
    chk("ce_level_held", BTN_LEVEL, 3'b001);
    BTN_RAW = 3'b000;
    for (int t = 1; t <= 30; t++) begin
      CE = t[0];
      step();
    end
    CE = 1'b1;
    hold(4);

    // Reset mid-repeat on SET while still held
    BTN_RAW = 3'b100;
    hold(20);
    CLR = 1'b1;
    step();
    chk("clr_level", BTN_LEVEL, 3'b000);
    chk("clr_pulse", BTN_PULSE, 3'b000);
    CLR = 1'b0;
    for (int t = 1; t <= 14; t++) begin
      step();
      chk("post_clr_pulse", BTN_PULSE, (t == 6 || t == 14) ? 3'b100 : 3'b000);
    end
    BTN_RAW = 3'b000;
    hold(10);

    // Simultaneous presses on all channels
    BTN_RAW = 3'b111;
    for (int t = 1; t <= 17; t++) begin
      step();
      chk("simul_pulse", BTN_PULSE,
          (t == 6) ? 3'b111 : ((t == 14 || t == 17) ? 3'b100 : 3'b000));
    end
    BTN_RAW = 3'b000;
    hold(10);

    // Randomized stimulus against the model
    for (int c = 0; c < 4000; c++) begin
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, 11) == 0) BTN_RAW[ch] = ~BTN_RAW[ch];
      CE  = ($urandom_range(0, 3) != 0);
      CLR = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
